title_stream_packer: RTL and testbench
======================================

# title_stream_packer

Downstream stage of the title overlay core: consumes its 16-bit RGB565 AXI-Stream output (`axim_s_*` of the title core) and packs pixel pairs into 32-bit AXI-Stream words for the S2MM DMA. It preserves frame boundaries (`last`), handles odd-length frames with a byte-lane keep mask, counts completed frames and raises a one-cycle frame-done pulse when the final word of a frame leaves the block.

## Interface
Parameters:
- `FRAME_PIXELS`, 307200, expected pixels per frame (640x480); used only by the length check.
- `CNT_W`, 16, width of `frame_count`.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `s00_axi_aresetn`  in  1  reset, asynchronous assert, active-low.
- `axis_s_data_in`  in  16  pixel from title core; first-accepted pixel of a pair goes to bits [15:0].
- `axis_s_valid`  in  1  input beat valid.
- `axis_s_ready`  out  1  input beat accepted when valid & ready.
- `axis_s_last`  in  1  last pixel of frame.
- `axim_s_data`  out  32  packed word to DMA.
- `axim_s_keep`  out  4  byte enables: 4'b1111 full word, 4'b0011 lone low pixel.
- `axim_s_valid`  out  1  output word valid.
- `axim_s_ready`  in  1  DMA ready.
- `axim_s_last`  out  1  word carries the frame's last pixel.
- `frame_done`  out  1  one-cycle pulse on handshake of a word with `axim_s_last`=1.
- `frame_count`  out  CNT_W  completed frames since reset.
- `len_err`  out  1  sticky frame-length error (length-check build only, else tied 0).
- `len_err_clr`  in  1  synchronous clear of `len_err` (ignored when the check is compiled out).

## Operation
- Two-state pack FSM: LOW (awaiting first pixel of pair), HIGH (low half held in pack register).
- LOW, accept, last=0: store pixel in pack[15:0], go HIGH; no push.
- LOW, accept, last=1: push {16'h0, pixel}, keep=4'b0011, last=1; stay LOW.
- HIGH, accept: push {pixel, pack[15:0]}, keep=4'b1111, last=axis_s_last; go LOW.
- Pushes enter a 2-entry output FIFO; FIFO head drives `axim_s_*`.
- `frame_count` increments on handshake of a last word; wraps 2^CNT_W-1 -> 0.
- Reset, including mid-frame: FSM to LOW, pack register and FIFO cleared, partial pair discarded, `frame_count`=0, `len_err`=0.

## Timing
- `axis_s_ready` = (FIFO count < 2); depends only on registered state, never on `axis_s_valid`/`axis_s_last`.
- Push and pop in the same cycle: count unchanged; head advances correctly at count 1 and count 2.
- Latency: word valid at `axim_s_*` the cycle after the accept that completes it.
- Sustained throughput with `axim_s_ready`=1: one pixel accepted every cycle, one word every two cycles, no bubbles.
- `axim_s_valid` held high with data/keep/last stable until handshake (AXI-Stream rule).
- `frame_done` asserts in the cycle following the last-word handshake, for exactly one cycle; `frame_count` updates in that same cycle.
- Reset values: `axis_s_ready`=0 during reset, 1 the first cycle after release; `axim_s_valid`=0, `axim_s_data`=0, `axim_s_keep`=0, `axim_s_last`=0, `frame_done`=0, `frame_count`=0, `len_err`=0.

## Configuration
- Macro `TITLE_PACKER_LEN_CHECK_EN`.
- Defined: 32-bit input pixel counter; `len_err` set when last is accepted with count+1 != FRAME_PIXELS, or when pixel FRAME_PIXELS is accepted without last. Counter restarts at 0 after every last. `len_err_clr` clears `len_err`; a new error in the same cycle takes priority. Data path unaffected.
- Not defined: counter absent, `len_err` tied 0, `len_err_clr` unused.

## Structure
- Shared package `title_pkg`: `pixel_t` (16 bits), `word_t` (32 bits), `keep_t` (4 bits), constants `KEEP_FULL`=4'b1111, `KEEP_LOW`=4'b0011, pack-state enum {LOW, HIGH}.
- One sub-module: `title_skid_fifo`, 2-entry FIFO of {word_t, keep_t, last}, with push/pop/count outputs.

## Test plan
- Pixels 0x0001..0x0004, last on 4th, `axim_s_ready`=1 -> words 0x00020001, 0x00040003 (keep F, last on second), `frame_done` pulse, `frame_count`=1.
- 3-pixel frame 0xAAAA, 0xBBBB, 0xCCCC -> 0xBBBBAAAA keep F, then 0x0000CCCC keep 3 last=1.
- `axim_s_ready`=0 during 8 valid pixels -> 4 accepted, `axis_s_ready`=0, words held stable; release -> 0 lost, 0 duplicated.
- Reset asserted after 1 pixel of pair, then new 2-pixel frame 0x1111, 0x2222 -> single word 0x22221111, `frame_count`=1.
- Preload `frame_count`=0xFFFF (65535 one-pixel frames) -> next frame wraps to 0x0000.
- With `TITLE_PACKER_LEN_CHECK_EN`, FRAME_PIXELS=4, last on pixel 3 -> `len_err`=1 until `len_err_clr`; 4-pixel frame after clear -> `len_err` stays 0.

Source files
------------

// File: rtl/title_pkg.sv
// title_pkg: types and constants shared by the title stream packer files.
//   pixel_t      16-bit RGB565 pixel
//   word_t       32-bit packed output word
//   keep_t       4-bit byte-lane enable
//   KEEP_FULL    both pixels of the word are valid
//   KEEP_LOW     only the low pixel is valid (odd-length frame tail)
//   pack_state_t LOW = waiting for first pixel of a pair, HIGH = low half held
//   beat_t       one output FIFO entry {data, keep, last}
package title_pkg;

    typedef logic [15:0] pixel_t;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  keep_t;

    localparam keep_t KEEP_FULL = 4'b1111;
    localparam keep_t KEEP_LOW  = 4'b0011;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } pack_state_t;

    typedef struct packed {
        word_t data;
        keep_t keep;
        logic  last;
    } beat_t;

endpackage

// File: rtl/title_stream_packer_if.sv
// title_stream_packer_if: both AXI-Stream links of the packer in one bundle.
//   axis_s_*  16-bit pixel stream from the title core into the packer
//   axim_s_*  32-bit word stream from the packer to the S2MM DMA
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high; a source holding valid keeps data/keep/last stable until then.
// Modports:
//   master  environment view: drives pixels in, consumes words out
//   slave   packer view: consumes pixels, drives words
interface title_stream_packer_if;
    import title_pkg::*;

    pixel_t axis_s_data_in;
    logic   axis_s_valid;
    logic   axis_s_ready;
    logic   axis_s_last;

    word_t  axim_s_data;
    keep_t  axim_s_keep;
    logic   axim_s_valid;
    logic   axim_s_ready;
    logic   axim_s_last;

    modport master (
        output axis_s_data_in, axis_s_valid, axis_s_last,
        input  axis_s_ready,
        input  axim_s_data, axim_s_keep, axim_s_valid, axim_s_last,
        output axim_s_ready
    );

    modport slave (
        input  axis_s_data_in, axis_s_valid, axis_s_last,
        output axis_s_ready,
        output axim_s_data, axim_s_keep, axim_s_valid, axim_s_last,
        input  axim_s_ready
    );

endinterface

// File: rtl/title_skid_fifo.sv
// title_skid_fifo: 2-entry FIFO of output beats.
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_beat (taken when not full, or full and popping)
//   push_beat   beat to store
//   pop         drop the head beat (ignored when empty)
//   head        oldest beat; all zero when empty
//   count       number of stored beats (0..2)
module title_skid_fifo
    import title_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       pop,
    output beat_t      head,
    output logic [1:0] count
);

    beat_t      slot0;
    beat_t      slot1;
    logic [1:0] cnt;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            cnt   <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) slot0 <= push_beat;
                    else             slot1 <= push_beat;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    // Emptied slots go back to zero so an idle output reads 0.
                    slot0 <= slot1;
                    slot1 <= '0;
                    cnt   <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        slot0 <= push_beat;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = slot0;
    assign count = cnt;

endmodule

// File: rtl/title_stream_packer.sv
// title_stream_packer: packs pairs of 16-bit RGB565 pixels into 32-bit
// AXI-Stream words, keeping frame boundaries and flagging odd tails with a
// low-pixel keep mask. Counts completed frames and pulses frame_done.
//   clk              clock, rising edge
//   s00_axi_aresetn  asynchronous active-low reset
//   bus              slave modport: axis_s_* pixel input, axim_s_* word output
//   frame_done       one-cycle pulse the cycle after a last word handshakes
//   frame_count      completed frames since reset (wraps)
//   len_err          sticky frame-length error
//   len_err_clr      synchronous clear of len_err
//   pack_state       current pack FSM state (debug observation)
// Optional build macro TITLE_PACKER_LEN_CHECK_EN enables the frame-length
// check against FRAME_PIXELS; without it len_err is tied 0.
module title_stream_packer
    import title_pkg::*;
#(
    parameter int FRAME_PIXELS = 307200,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 s00_axi_aresetn,
    title_stream_packer_if.slave bus,
    output logic                 frame_done,
    output logic [CNT_W-1:0]     frame_count,
    output logic                 len_err,
    input  logic                 len_err_clr,
    output pack_state_t          pack_state
);

    pack_state_t state;
    pack_state_t state_next;
    pixel_t      pack_low;
    logic        ready_en;
    logic [1:0]  fifo_count;
    beat_t       head;
    beat_t       push_beat;
    logic        push;
    logic        load_low;
    logic        accept;
    logic        pop;

    // ready_en keeps the input closed during reset and opens it on the first
    // edge after release; afterwards only the registered FIFO fill matters.
    assign bus.axis_s_ready = ready_en && (fifo_count != 2'd2);
    assign accept           = bus.axis_s_valid && bus.axis_s_ready;
    assign pop              = bus.axim_s_valid && bus.axim_s_ready;

    always_ff @(posedge clk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state <= LOW;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                LOW:     if (!bus.axis_s_last) state_next = HIGH;
                HIGH:    state_next = LOW;
                default: state_next = LOW;
            endcase
        end
    end

    always_comb begin
        push      = 1'b0;
        load_low  = 1'b0;
        push_beat = '0;
        if (accept) begin
            case (state)
                LOW: begin
                    if (bus.axis_s_last) begin
                        push           = 1'b1;
                        push_beat.data = {16'h0000, bus.axis_s_data_in};
                        push_beat.keep = KEEP_LOW;
                        push_beat.last = 1'b1;
                    end else begin
                        load_low = 1'b1;
                    end
                end
                HIGH: begin
                    push           = 1'b1;
                    push_beat.data = {bus.axis_s_data_in, pack_low};
                    push_beat.keep = KEEP_FULL;
                    push_beat.last = bus.axis_s_last;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            pack_low    <= '0;
            ready_en    <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            ready_en   <= 1'b1;
            frame_done <= pop && head.last;
            if (load_low) pack_low <= bus.axis_s_data_in;
            if (pop && head.last) frame_count <= frame_count + CNT_W'(1);
        end
    end

    title_skid_fifo u_fifo (
        .clk       (clk),
        .rst_n     (s00_axi_aresetn),
        .push      (push),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign bus.axim_s_valid = (fifo_count != 2'd0);
    assign bus.axim_s_data  = head.data;
    assign bus.axim_s_keep  = head.keep;
    assign bus.axim_s_last  = head.last;
    assign pack_state       = state;

`ifdef TITLE_PACKER_LEN_CHECK_EN
    logic [31:0] pix_cnt;
    logic        len_hit;

    // pix_cnt holds pixels already accepted in this frame, so pix_cnt + 1 is
    // the index of the pixel being accepted now.
    always_comb begin
        len_hit = 1'b0;
        if (accept) begin
            if (bus.axis_s_last) len_hit = (pix_cnt + 32'd1) != 32'(FRAME_PIXELS);
            else                 len_hit = (pix_cnt + 32'd1) == 32'(FRAME_PIXELS);
        end
    end

    always_ff @(posedge clk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            pix_cnt <= '0;
            len_err <= 1'b0;
        end else begin
            if (accept) pix_cnt <= bus.axis_s_last ? 32'd0 : pix_cnt + 32'd1;
            if (len_hit)          len_err <= 1'b1;
            else if (len_err_clr) len_err <= 1'b0;
        end
    end
`else
    logic unused_len_err_clr;
    localparam int unused_frame_pixels = FRAME_PIXELS;
    assign unused_len_err_clr = len_err_clr;
    assign len_err            = 1'b0;
`endif

endmodule

// File: tb/tb_title_stream_packer.sv
// tb_title_stream_packer: self-checking bench for title_stream_packer.
// A reference model built from pixel lists predicts every output word,
// the input ready, frame_done/frame_count and len_err on each cycle.
module tb_title_stream_packer;
    import title_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        len_err;
    logic        len_err_clr;
    pack_state_t pack_state;

    title_stream_packer_if bus();

    title_stream_packer #(
        .FRAME_PIXELS (4),
        .CNT_W        (16)
    ) dut (
        .clk             (clk),
        .s00_axi_aresetn (rst_n),
        .bus             (bus),
        .frame_done      (frame_done),
        .frame_count     (frame_count),
        .len_err         (len_err),
        .len_err_clr     (len_err_clr),
        .pack_state      (pack_state)
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    logic [36:0] exp_q[$];     // expected output beats {data, keep, last}
    logic [36:0] obs_q[$];     // beats that handshook, for literal checks
    pixel_t      cur_px[$];    // accepted pixels not yet forming a word
    logic [16:0] px_q[$];      // driver input {last, pixel}
    logic        fd_exp;
    logic [15:0] cnt_exp;
    logic        err_exp;
    bit          armed;
    int          px_in_frame;
    int          acc_count;
    int          fd_pulses;
    bit          rand_ready;
    bit          rand_gap;
    int          sz;
    logic [36:0] b;
    logic        set_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model + compare (every negedge) ----------------
    initial begin
        fd_exp = 1'b0; cnt_exp = '0; err_exp = 1'b0; armed = 0; px_in_frame = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_in_ready",   bus.axis_s_ready, 0);
                check("rst_out_valid",  bus.axim_s_valid, 0);
                check("rst_out_beat",   {bus.axim_s_data, bus.axim_s_keep, bus.axim_s_last}, 0);
                check("rst_frame_done", frame_done, 0);
                check("rst_frame_cnt",  frame_count, 0);
                check("rst_len_err",    len_err, 0);
                exp_q.delete(); cur_px.delete();
                fd_exp = 1'b0; cnt_exp = '0; err_exp = 1'b0; armed = 0; px_in_frame = 0;
            end else begin
                sz = exp_q.size();
                check("in_ready",   bus.axis_s_ready, armed && (sz < 2));
                check("out_valid",  bus.axim_s_valid, sz > 0);
                if (sz > 0)
                    check("out_beat", {bus.axim_s_data, bus.axim_s_keep, bus.axim_s_last}, exp_q[0]);
                check("frame_done", frame_done, fd_exp);
                check("frame_cnt",  frame_count, cnt_exp);
                check("len_err",    len_err, err_exp);
                check("pack_state", pack_state, (cur_px.size() == 1) ? HIGH : LOW);
                if (frame_done) fd_pulses++;

                // advance the model by what the coming edge will transfer
                fd_exp = 1'b0;
                if (sz > 0 && bus.axim_s_ready) begin
                    b = exp_q.pop_front();
                    obs_q.push_back(b);
                    if (b[0]) begin
                        fd_exp  = 1'b1;
                        cnt_exp = cnt_exp + 16'd1;
                    end
                end
                set_err = 1'b0;
                if (armed && sz < 2 && bus.axis_s_valid) begin
                    acc_count++;
                    cur_px.push_back(bus.axis_s_data_in);
                    if (cur_px.size() == 2) begin
                        exp_q.push_back({cur_px[1], cur_px[0], 4'hF, bus.axis_s_last});
                        cur_px.delete();
                    end else if (bus.axis_s_last) begin
                        exp_q.push_back({16'h0000, cur_px[0], 4'h3, 1'b1});
                        cur_px.delete();
                    end
                    px_in_frame++;
                    if (bus.axis_s_last) begin
                        set_err = (px_in_frame != 4);
                        px_in_frame = 0;
                    end else begin
                        set_err = (px_in_frame == 4);
                    end
                end
`ifdef TITLE_PACKER_LEN_CHECK_EN
                if (set_err)          err_exp = 1'b1;
                else if (len_err_clr) err_exp = 1'b0;
`endif
                armed = 1;
            end
        end
    end

    // ---------------- drivers ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.axim_s_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_all();
        int  budget;
        bit  hs;
        while (px_q.size() > 0) begin
            if (rand_gap) begin
                bus.axis_s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            {bus.axis_s_last, bus.axis_s_data_in} = px_q.pop_front();
            bus.axis_s_valid = 1'b1;
            budget = 0;
            do begin
                @(negedge clk);
                hs = bus.axis_s_ready;
                tick();
                budget++;
            end while (!hs && budget < 1000);
            if (!hs) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no accept expected accept within 1000 cycles");
                px_q.delete();
            end
        end
        bus.axis_s_valid = 1'b0;
        bus.axis_s_last  = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 2000) begin
            tick();
            budget++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (2) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic add_frame(input int n, input int base);
        for (int i = 0; i < n; i++)
            px_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, 16'(base + i)});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int total;
        rst_n = 1'b0;
        bus.axis_s_valid = 1'b0; bus.axis_s_last = 1'b0; bus.axis_s_data_in = '0;
        bus.axim_s_ready = 1'b1; len_err_clr = 1'b0;
        rand_ready = 0; rand_gap = 0; fd_pulses = 0; acc_count = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 4-pixel frame, ready high
        obs_q.delete(); fd_pulses = 0;
        add_frame(4, 1);
        send_all();
        drain();
        check("t1_words",  obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("t1_w0", obs_q[0], {32'h00020001, 4'hF, 1'b0});
            check("t1_w1", obs_q[1], {32'h00040003, 4'hF, 1'b1});
        end
        check("t1_fdone", fd_pulses, 1);
        check("t1_count", frame_count, 16'd1);

        // 3-pixel frame -> odd tail
        obs_q.delete();
        px_q.push_back({1'b0, 16'hAAAA});
        px_q.push_back({1'b0, 16'hBBBB});
        px_q.push_back({1'b1, 16'hCCCC});
        send_all();
        drain();
        check("t2_words", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("t2_w0", obs_q[0], {32'hBBBBAAAA, 4'hF, 1'b0});
            check("t2_w1", obs_q[1], {32'h0000CCCC, 4'h3, 1'b1});
        end
        check("t2_count", frame_count, 16'd2);
        check("t2_len_err", len_err,
`ifdef TITLE_PACKER_LEN_CHECK_EN
              1
`else
              0
`endif
        );

        // back-pressure: 8 pixels offered while DMA stalls
        obs_q.delete(); acc_count = 0;
        bus.axim_s_ready = 1'b0;
        add_frame(8, 16'h0101);
        fork
            send_all();
            begin
                repeat (10) tick();
                check("t3_accepted", acc_count, 4);
                check("t3_in_ready", bus.axis_s_ready, 0);
                bus.axim_s_ready = 1'b1;
            end
        join
        drain();
        check("t3_words", obs_q.size(), 4);
        for (int k = 0; k < 4 && k < obs_q.size(); k++)
            check("t3_w", obs_q[k][36:5], {16'(16'h0102 + 2 * k), 16'(16'h0101 + 2 * k)});
        check("t3_count", frame_count, 16'd3);

        // randomized frames, gaps and back-pressure
        rand_ready = 1; rand_gap = 1;
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(1, 9);
            for (int i = 0; i < n; i++)
                px_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, 16'($urandom_range(0, 65535))});
        end
        send_all();
        rand_ready = 0; rand_gap = 0;
        bus.axim_s_ready = 1'b1;
        drain();
        check("t4_count", frame_count, 16'd43);

        // reset in the middle of a pair
        px_q.push_back({1'b0, 16'h5555});
        send_all();
        check("t5_pending", pack_state, HIGH);
        do_reset();
        obs_q.delete();
        px_q.push_back({1'b0, 16'h1111});
        px_q.push_back({1'b1, 16'h2222});
        send_all();
        drain();
        check("t5_words", obs_q.size(), 1);
        if (obs_q.size() == 1) check("t5_w0", obs_q[0], {32'h22221111, 4'hF, 1'b1});
        check("t5_count", frame_count, 16'd1);

        // frame counter wrap
        do_reset();
        total = 65535;
        for (int i = 0; i < total; i++) px_q.push_back({1'b1, 16'(i)});
        send_all();
        drain();
        check("t6_count_max", frame_count, 16'hFFFF);
        fd_pulses = 0;
        px_q.push_back({1'b1, 16'h7777});
        send_all();
        drain();
        check("t6_count_wrap", frame_count, 16'h0000);
        check("t6_fdone", fd_pulses, 1);

        // length check: short frame, clear, then correct frame
        do_reset();
        add_frame(3, 16'h0300);
        send_all();
        drain();
        repeat (3) tick();
`ifdef TITLE_PACKER_LEN_CHECK_EN
        check("t7_err_set", len_err, 1);
`else
        check("t7_err_off", len_err, 0);
`endif
        len_err_clr = 1'b1;
        tick();
        len_err_clr = 1'b0;
        tick();
        check("t7_err_clr", len_err, 0);
        add_frame(4, 16'h0400);
        send_all();
        drain();
        check("t7_err_ok", len_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
